// File: rtl/fetch_redirect_unit_if.sv
// Bundle of the fetch-stage control inputs and PC/flush outputs of fetch_redirect_unit.
// master drives the hazard/EX inputs; slave is the fetch redirect unit itself.
interface fetch_redirect_unit_if;
  logic        stall_in;
  logic        branch_resolved_in;
  logic        branch_taken_in;
  logic [31:0] branch_target_in;
  logic [31:0] ex_pc_in;
  logic        ex_pred_taken_in;
  logic [31:0] pc_out;
  logic [31:0] pc_plus_4_out;
  logic        fetch_valid_out;
  logic        pred_taken_out;
  logic        if_id_flush_out;
  logic        id_ex_flush_out;
  logic [15:0] redirect_count_out;

  modport master (
    output stall_in, branch_resolved_in, branch_taken_in, branch_target_in,
           ex_pc_in, ex_pred_taken_in,
    input  pc_out, pc_plus_4_out, fetch_valid_out, pred_taken_out,
           if_id_flush_out, id_ex_flush_out, redirect_count_out
  );

  modport slave (
    input  stall_in, branch_resolved_in, branch_taken_in, branch_target_in,
           ex_pc_in, ex_pred_taken_in,
    output pc_out, pc_plus_4_out, fetch_valid_out, pred_taken_out,
           if_id_flush_out, id_ex_flush_out, redirect_count_out
  );
endinterface

// File: rtl/fetch_redirect_unit.sv
// Fetch PC sequencer with EX-stage mispredict redirect, IF/ID + ID/EX flush and redirect counter.
// Optional 4-entry direct-mapped BTB enabled by defining FETCH_REDIRECT_BTB_EN.
module fetch_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                  clk,
  input logic                  rst,
  fetch_redirect_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [15:0] cnt_q, cnt_d;
  logic        mispredict;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [31:0] pc_plus_4;
  logic [31:0] corrected_pc;

  // The low target bits are architecturally ignored; the wire name keeps lint quiet.
  logic unused_target_lsbs;
  assign unused_target_lsbs = ^bus.branch_target_in[1:0];

  assign pc_plus_4    = pc_q + 32'd4;
  assign corrected_pc = bus.branch_taken_in ? {bus.branch_target_in[31:2], 2'b00}
                                            : bus.ex_pc_in + 32'd4;

`ifdef FETCH_REDIRECT_BTB_EN
  logic [3:0]  btb_valid_q;
  logic [27:0] btb_tag_q [4];
  logic [29:0] btb_tgt_q [4];
  logic [1:0]  lookup_idx;
  logic [1:0]  update_idx;
  logic        update_tag_hit;

  assign lookup_idx     = pc_q[3:2];
  assign update_idx     = bus.ex_pc_in[3:2];
  // Lookup reads the registered arrays, so a same-cycle update is seen only next cycle.
  assign pred_taken     = btb_valid_q[lookup_idx] && (btb_tag_q[lookup_idx] == pc_q[31:4]);
  assign pred_target    = {btb_tgt_q[lookup_idx], 2'b00};
  assign update_tag_hit = btb_valid_q[update_idx] && (btb_tag_q[update_idx] == bus.ex_pc_in[31:4]);
  assign mispredict     = bus.branch_resolved_in & (bus.branch_taken_in != bus.ex_pred_taken_in);

  always_ff @(posedge clk) begin
    if (rst) begin
      btb_valid_q <= '0;
    end else if (bus.branch_resolved_in) begin
      if (bus.branch_taken_in)  btb_valid_q[update_idx] <= 1'b1;
      else if (update_tag_hit)  btb_valid_q[update_idx] <= 1'b0;
    end
  end

  // NOTE: tag/target storage has no reset; the valid bits alone make stale entries harmless.
  always_ff @(posedge clk) begin
    if (!rst && bus.branch_resolved_in && bus.branch_taken_in) begin
      btb_tag_q[update_idx] <= bus.ex_pc_in[31:4];
      btb_tgt_q[update_idx] <= bus.branch_target_in[31:2];
    end
  end
`else
  logic unused_ex_pred;
  assign unused_ex_pred = bus.ex_pred_taken_in;
  assign pred_taken     = 1'b0;
  assign pred_target    = pc_plus_4;
  assign mispredict     = bus.branch_resolved_in & bus.branch_taken_in;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   if (bus.stall_in && !mispredict) state_d = HOLD;
      HOLD:    if (!bus.stall_in || mispredict) state_d = FETCH;
      default: state_d = IDLE;
    endcase

    if (mispredict)                              pc_d = corrected_pc;
    else if (state_q == IDLE || bus.stall_in)    pc_d = pc_q;
    else if (pred_taken)                         pc_d = pred_target;
    else                                         pc_d = pc_plus_4;

    if (mispredict && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  assign bus.pc_out             = pc_q;
  assign bus.pc_plus_4_out      = pc_plus_4;
  assign bus.fetch_valid_out    = (state_q != IDLE);
  assign bus.pred_taken_out     = pred_taken;
  assign bus.if_id_flush_out    = mispredict;
  assign bus.id_ex_flush_out    = mispredict;
  assign bus.redirect_count_out = cnt_q;

endmodule
